cmos_persist: RTL and testbench

Save/restore engine for the 1024×4 battery-backed CMOS RAM.
- Sits between the CPU's CMOS chip-select path and the CMOS RAM.
- When idle, CPU accesses pass straight through to the RAM.
- On command, it takes ownership of the RAM and performs one of two transfers over byte streams, packed two nibbles per byte:
  - dumps all 1024 nibbles to a host byte stream (UART/loader side), or
  - loads all 1024 nibbles from the host byte stream.
- Each transfer is followed by an 8-bit checksum byte, so high-score and audit settings survive power cycles of the FPGA.

---
 rtl/cmos_persist_pkg.sv | 35 +++
 rtl/cmos_persist.sv | 227 ++++++++++++++++++++++
 tb/tb_cmos_persist.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cmos_persist_pkg.sv
// cmos_persist_pkg: sizes, FSM state type and address helper shared by the
// CMOS RAM save/restore engine.
package cmos_persist_pkg;

  // Geometry of the battery-backed CMOS RAM (1024 x 4) and its byte view.
  localparam int CMOS_NIBBLES = 1024;
  localparam int CMOS_BYTES   = 512;
  localparam int IDX_W        = 9;
  localparam int ADDR_W       = $clog2(CMOS_NIBBLES);

  // Last byte index of a transfer; the loop leaves here instead of wrapping.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMOS_BYTES - 1);

  // Transfer sequencer states.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_LO = 4'd1,
    RD_HI = 4'd2,
    CAP   = 4'd3,
    SEND  = 4'd4,
    SUM   = 4'd5,
    RECV  = 4'd6,
    WR_LO = 4'd7,
    WR_HI = 4'd8,
    LSUM  = 4'd9,
    DONE  = 4'd10
  } state_t;

  // Nibble address of one half of a byte: even address holds bits [3:0].
  function automatic logic [ADDR_W-1:0] nib_addr(input logic [IDX_W-1:0] idx,
                                                 input logic             hi);
    nib_addr = {idx, hi};
  endfunction

endpackage

// File: rtl/cmos_persist.sv
// cmos_persist: save/restore engine for the 1024x4 CMOS RAM. Passes CPU
// accesses through while idle; on command dumps the RAM to, or loads it from,
// a host byte stream (two nibbles per byte) followed by an 8-bit checksum.
module cmos_persist
  import cmos_persist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_dump,
  input  logic              cmd_load,
  output logic              busy,
  output logic              done,
  output logic              sum_error,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_data_in,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_data_in,
  input  logic [3:0]        ram_data_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [3:0]       lo_q, lo_d;        // low nibble captured during a dump
  logic [7:0]       byte_q, byte_d;    // byte being sent or written
  logic             sum_error_q, sum_error_d;

  logic             last_s;
  logic             tx_hs_s;
  logic             rx_hs_s;

  assign last_s  = (idx_q == IDX_LAST);
  assign tx_hs_s = tx_valid && tx_ready;
  assign rx_hs_s = rx_valid && rx_ready;

  // Next-state logic for the sequencer, index, checksum and byte registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    lo_d        = lo_q;
    byte_d      = byte_q;
    sum_error_d = sum_error_q;

    case (state_q)
      IDLE: begin
        if (cmd_dump) begin
          state_d     = RD_LO;
          idx_d       = '0;
          sum_d       = 8'h00;
          sum_error_d = 1'b0;
        end else if (cmd_load) begin
          state_d     = RECV;
          idx_d       = '0;
          sum_d       = 8'h00;
          sum_error_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      RD_LO: begin
        state_d = RD_HI;
      end

      // Read data from the RD_LO access is valid during this cycle.
      RD_HI: begin
        lo_d    = ram_data_out;
        state_d = CAP;
      end

      // Read data from the RD_HI access completes the byte.
      CAP: begin
        byte_d  = {ram_data_out, lo_q};
        state_d = SEND;
      end

      SEND: begin
        if (tx_hs_s) begin
          sum_d = sum_q + byte_q;
          if (last_s) begin
            state_d = SUM;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = RD_LO;
          end
        end else begin
          state_d = SEND;
        end
      end

      SUM: begin
        if (tx_hs_s) begin
          state_d = DONE;
        end else begin
          state_d = SUM;
        end
      end

      RECV: begin
        if (rx_hs_s) begin
          byte_d  = rx_data;
          state_d = WR_LO;
        end else begin
          state_d = RECV;
        end
      end

      WR_LO: begin
        state_d = WR_HI;
      end

      WR_HI: begin
        sum_d = sum_q + byte_q;
        if (last_s) begin
          state_d = LSUM;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = RECV;
        end
      end

      // Written data stays in RAM even on mismatch; software reinitialises.
      LSUM: begin
        if (rx_hs_s) begin
          sum_error_d = (rx_data != sum_q);
          state_d     = DONE;
        end else begin
          state_d = LSUM;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= 8'h00;
      lo_q        <= 4'h0;
      byte_q      <= 8'h00;
      sum_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      lo_q        <= lo_d;
      byte_q      <= byte_d;
      sum_error_q <= sum_error_d;
    end
  end

  // RAM port mux: CPU passthrough in IDLE, engine-owned otherwise.
  always_comb begin
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = 4'h0;

    case (state_q)
      IDLE: begin
        ram_cs      = cpu_cs;
        ram_we      = cpu_we;
        ram_addr    = cpu_addr;
        ram_data_in = cpu_data_in;
      end
      RD_LO: begin
        ram_cs   = 1'b1;
        ram_addr = nib_addr(idx_q, 1'b0);
      end
      RD_HI: begin
        ram_cs   = 1'b1;
        ram_addr = nib_addr(idx_q, 1'b1);
      end
      WR_LO: begin
        ram_cs      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = nib_addr(idx_q, 1'b0);
        ram_data_in = byte_q[3:0];
      end
      WR_HI: begin
        ram_cs      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = nib_addr(idx_q, 1'b1);
        ram_data_in = byte_q[7:4];
      end
      default: begin
        ram_cs = 1'b0;
      end
    endcase
  end

  // Stream and status outputs decoded from registered state; tx_data only
  // changes on a state/register update, so it holds while stalled.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    sum_error = sum_error_q;
    tx_valid  = (state_q == SEND) || (state_q == SUM);
    rx_ready  = (state_q == RECV) || (state_q == LSUM);
    if (state_q == SUM) begin
      tx_data = sum_q;
    end else begin
      tx_data = byte_q;
    end
  end

endmodule

// File: tb/tb_cmos_persist.sv
// tb_cmos_persist: directed bench for the CMOS save/restore engine with a
// behavioural 1024x4 RAM model.
module tb_cmos_persist;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_dump = 1'b0;
  logic       cmd_load = 1'b0;
  logic       busy, done, sum_error;
  logic       cpu_cs = 1'b0;
  logic       cpu_we = 1'b0;
  logic [9:0] cpu_addr = 10'd0;
  logic [3:0] cpu_data_in = 4'h0;
  logic       ram_cs, ram_we;
  logic [9:0] ram_addr;
  logic [3:0] ram_data_in;
  logic [3:0] ram_data_out = 4'h0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;

  logic [3:0] mem [0:1023];
  logic       preload = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  cmos_persist dut (
    .clk(clk), .reset(reset), .cmd_dump(cmd_dump), .cmd_load(cmd_load),
    .busy(busy), .done(done), .sum_error(sum_error),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // RAM model: sync write, registered read data held between reads.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'(i);
    end else if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_data_in;
      else        ram_data_out  <= mem[ram_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    tick();
    preload = 1'b0;
  endtask

  // Dump run. Expected data: pattern nibble[a]=a[3:0] or all 0xA5 bytes;
  // both give a checksum of 0x00 (1080*64 and 165*512 are multiples of 256).
  task automatic run_dump(input bit toggle, input bit a5, input bit both_cmds);
    int cyc, nbytes, nrx, first_tx;
    bit stalled;
    logic [7:0] prev, expb;
    cyc = 1; nbytes = 0; nrx = 0; first_tx = 0; stalled = 1'b0; prev = 8'h00;
    cmd_dump = 1'b1;
    cmd_load = both_cmds;
    tick();
    cmd_dump = 1'b0;
    cmd_load = 1'b0;
    check_val("busy_rise", 32'(busy), 32'd1);
    check_val("err_clr", 32'(sum_error), 32'd0);
    while (!done && cyc < 6000) begin
      if (stalled) begin
        check_val("stall_valid", 32'(tx_valid), 32'd1);
        check_val("stall_data", 32'(tx_data), 32'(prev));
      end
      if (rx_ready) nrx++;
      if (tx_valid && first_tx == 0) first_tx = cyc;
      tx_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        if (nbytes < 512) expb = a5 ? 8'hA5 : {4'(2 * nbytes + 1), 4'(2 * nbytes)};
        else              expb = 8'h00;
        check_val("dump_byte", 32'(tx_data), 32'(expb));
        nbytes++;
      end
      stalled = tx_valid && !tx_ready;
      prev    = tx_data;
      tick();
      cyc++;
    end
    check_val("dump_done", 32'(done), 32'd1);
    check_val("dump_nbytes", 32'(nbytes), 32'd513);
    check_val("first_tx", 32'(first_tx), 32'd4);
    if (!toggle) check_val("dump_cycles", 32'(cyc), 32'd2050);
    if (both_cmds) check_val("rx_ready_in_dump", 32'(nrx), 32'd0);
    tx_ready = 1'b0;
    tick();
    check_val("done_pulse", 32'(done), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
  endtask

  // Load 512 bytes of 0xA5 then csum; optionally reset during WR_HI of byte 100.
  task automatic run_load(input logic [7:0] csum, input bit rst_mid);
    int cyc, ptr;
    bit pend, hit;
    cyc = 1; ptr = 0; pend = 1'b0; hit = 1'b0;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    while (!done && !hit && cyc < 6000) begin
      if (pend) ptr++;
      rx_valid = 1'b1;
      rx_data  = (ptr < 512) ? 8'hA5 : csum;
      pend     = rx_ready;
      if (rst_mid && ram_cs && ram_we && ram_addr == 10'd201) begin
        reset = 1'b1;
        hit   = 1'b1;
      end
      tick();
      cyc++;
    end
    rx_valid = 1'b0;
    if (rst_mid) begin
      check_val("rst_hit", 32'(hit), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
      check_val("rst_ram_cs", 32'(ram_cs), 32'd0);
      reset = 1'b0;
    end else begin
      check_val("load_done", 32'(done), 32'd1);
      check_val("load_cycles", 32'(cyc), 32'd1538);
      check_val("load_bytes", 32'(ptr), 32'd512);
    end
    tick();
  endtask

  task automatic check_a5_ram(input string tag, input int lo, input int hi);
    int cnt;
    cnt = 0;
    for (int i = lo; i <= hi; i++)
      if (mem[i] !== ((i % 2 == 0) ? 4'h5 : 4'hA)) cnt++;
    check_val(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    int cnt;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155; cpu_data_in = 4'h3;
    repeat (3) tick();
    check_val("rst_busy0", 32'(busy), 32'd0);
    check_val("rst_done0", 32'(done), 32'd0);
    check_val("rst_err0", 32'(sum_error), 32'd0);
    check_val("rst_txv0", 32'(tx_valid), 32'd0);
    check_val("rst_rxr0", 32'(rx_ready), 32'd0);
    check_val("rst_pass_addr", 32'(ram_addr), 32'h155);
    reset = 1'b0;

    // CPU passthrough write then read of 0x3FF.
    cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_data_in = 4'h7;
    #1;
    check_val("pt_cs", 32'(ram_cs), 32'd1);
    check_val("pt_we", 32'(ram_we), 32'd1);
    check_val("pt_addr", 32'(ram_addr), 32'h3FF);
    check_val("pt_din", 32'(ram_data_in), 32'h7);
    tick();
    cpu_we = 1'b0;
    tick();
    check_val("pt_read", 32'(ram_data_out), 32'h7);
    cpu_cs = 1'b0;

    // Dump of pattern RAM, both commands together -> dump wins.
    do_preload();
    run_dump(1'b0, 1'b0, 1'b1);
    // Dump with tx_ready 1-in-3.
    run_dump(1'b1, 1'b0, 1'b0);

    // Good load: 512 * 0xA5 sums to 0x00.
    run_load(8'h00, 1'b0);
    check_val("load_ok_err", 32'(sum_error), 32'd0);
    check_a5_ram("load_ok_ram", 0, 1023);

    // Bad checksum: sticky error, RAM still written, cleared by next dump.
    do_preload();
    run_load(8'h4A, 1'b0);
    check_val("load_bad_err", 32'(sum_error), 32'd1);
    check_a5_ram("load_bad_ram", 0, 1023);
    tick();
    check_val("err_sticky", 32'(sum_error), 32'd1);
    run_dump(1'b0, 1'b1, 1'b0);

    // Reset during WR_HI of byte 100.
    do_preload();
    run_load(8'h00, 1'b1);
    check_a5_ram("rst_ram_written", 0, 200);
    cnt = 0;
    for (int i = 202; i < 1024; i++)
      if (mem[i] !== 4'(i)) cnt++;
    check_val("rst_ram_kept", 32'(cnt), 32'd0);
    repeat (3) tick();
    check_val("rst_stay_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
